// File: rtl/sysid_ext_slave.sv
// sysid_ext_slave: Avalon-MM system-ID slave with scratch, uptime counter, snapshot and pipelined reads.
// Optional heartbeat output enabled by defining SYSID_HEARTBEAT_EN.
module sysid_ext_slave #(
  parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
  parameter int          UPTIME_W     = 48,
  parameter int          PRESCALE     = 1,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
`ifdef SYSID_HEARTBEAT_EN
  ,
  output logic        heartbeat
`endif
);
`ifdef SYSID_HEARTBEAT_EN
  localparam logic HB_CAP = 1'b1;
`else
  localparam logic HB_CAP = 1'b0;
`endif
  localparam logic [31:0] CAPS = {21'd0, HB_CAP, 2'(READ_LATENCY), 8'(UPTIME_W)};
  logic [15:0]          presc;
  logic [UPTIME_W-1:0]  uptime;
  logic [63:0]          up64;
  logic [31:0]          snap;
  logic [31:0]          scratch;
  logic                 freeze;
  logic                 wr_ctl;
  logic                 clear;
  logic                 tick;
  logic [31:0]          rdata;
  logic [READ_LATENCY-1:0] vld;
  logic [31:0]          dat [READ_LATENCY];
  assign up64   = 64'(uptime);
  assign wr_ctl = write && address == 3'd6 && byteenable[0];
  assign clear  = wr_ctl && writedata[0];
  assign tick   = !freeze && presc == 16'(PRESCALE - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      presc  <= '0;
      uptime <= '0;
    end else if (clear) begin
      presc  <= '0;
      uptime <= '0;
    end else if (!freeze) begin
      presc  <= tick ? 16'd0 : presc + 16'd1;
      uptime <= tick ? uptime + UPTIME_W'(1) : uptime;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) freeze <= 1'b0;
    else if (wr_ctl) freeze <= writedata[1];
  end
  // Upper bits are latched on the same cycle the low word is sampled, so a later word-4 read is coherent.
  always_ff @(posedge clock) begin
    if (reset) snap <= '0;
    else if (read && address == 3'd3) snap <= up64[63:32];
  end
  always_ff @(posedge clock) begin
    if (reset) scratch <= SCRATCH_INIT;
    else if (write && address == 3'd2)
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) scratch[8*i +: 8] <= writedata[8*i +: 8];
  end
`ifdef SYSID_HEARTBEAT_EN
  always_ff @(posedge clock) begin
    if (reset || clear) heartbeat <= 1'b0;
    else if (tick && uptime[0]) heartbeat <= ~heartbeat;
  end
`endif
  always_comb begin
    rdata = 32'd0;
    case (address)
      3'd0: rdata = ID_VALUE;
      3'd1: rdata = TIMESTAMP;
      3'd2: rdata = scratch;
      3'd3: rdata = up64[31:0];
      3'd4: rdata = snap;
      3'd5: rdata = CAPS;
      3'd6: rdata = {30'd0, freeze, 1'b0};
      default: rdata = 32'd0;
    endcase
  end
  // Read pipeline: stage 0 captures the read-cycle value, the last stage drives the bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat[i] <= '0;
    end else begin
      vld    <= READ_LATENCY'({vld, read});
      dat[0] <= rdata;
      for (int i = 1; i < READ_LATENCY; i++) dat[i] <= dat[i-1];
    end
  end
  assign readdata      = dat[READ_LATENCY-1];
  assign readdatavalid = vld[READ_LATENCY-1];
endmodule
